// File: rtl/qnigma_sum_ctrl.sv
// Frame-averaging controller: gathers 2**N samples per frame, sums them in a
// pipelined adder tree and presents the sum or mean on a valid/ready output.

module qnigma_sum #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 2
) (
  input  logic                      clk,
  input  logic [2**N-1:0][W-1:0]    data,
  output logic [W+N-1:0]            sum
);

  localparam int unsigned NS = 2**N;
  localparam int unsigned OW = W + N;

  // Heap-ordered tree: node 1 is the root, node k sums children 2k and 2k+1.
  logic [OW-1:0] leaf [NS];
  logic [OW-1:0] node [1:NS-1];

  for (genvar i = 0; i < NS; i++) begin : g_leaf
    assign leaf[i] = OW'(data[i]);
  end

  for (genvar k = 1; k < NS; k++) begin : g_node
    if (2 * k >= NS) begin : g_bottom
      always_ff @(posedge clk) node[k] <= leaf[2*k-NS] + leaf[2*k+1-NS];
    end else begin : g_inner
      always_ff @(posedge clk) node[k] <= node[2*k] + node[2*k+1];
    end
  end

  assign sum = node[1];

endmodule

module qnigma_sum_ctrl #(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 2,
  parameter int unsigned MEAN  = 1,
  parameter int unsigned ROUND = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W+N-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic [N-1:0]   fill_cnt
);

  localparam int unsigned NS = 2**N;
  localparam int unsigned OW = W + N;
  localparam int unsigned LW = $clog2(N + 1);
  localparam logic [OW:0] SAT = {{(N+1){1'b0}}, {W{1'b1}}};

  typedef enum logic [1:0] {IDLE, SUM, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [LW-1:0]          lat_q, lat_d;
  logic [NS-1:0][W-1:0]   coll_q, snap_q, snap_d;
  logic [OW-1:0]          tree_sum, res_c;
  logic [OW:0]            rnd_c;
  logic                   full, beat, last_beat, snap_load, res_load;

  // The last sample is only refused while the previous frame cannot retire this cycle.
  assign full      = (fill_cnt == N'(NS-1));
  assign in_ready  = !(full && (state_q != IDLE) && !((state_q == HOLD) && out_ready));
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && full;

  // Next state and datapath load strobes.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    snap_load = 1'b0;
    res_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (last_beat) begin
          state_d   = SUM;
          lat_d     = '0;
          snap_load = 1'b1;
        end
      end
      SUM: begin
        if (lat_q == LW'(N)) begin
          state_d  = HOLD;
          res_load = 1'b1;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (last_beat) begin
            state_d   = SUM;
            lat_d     = '0;
            snap_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; clr acts as a frame flush identical to rst.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      out_valid <= (state_d == HOLD);
      busy      <= (state_d != IDLE);
      if (beat) fill_cnt <= fill_cnt + N'(1);
    end
  end

  // Snapshot includes the sample arriving on the last beat.
  always_comb begin
    snap_d         = coll_q;
    snap_d[NS-1]   = in_data;
  end

  always_ff @(posedge clk) begin
    if (beat)      coll_q[fill_cnt] <= in_data;
    if (snap_load) snap_q           <= snap_d;
    if (res_load)  out_data         <= res_c;
  end

  qnigma_sum #(.W(W), .N(N)) u_sum (
    .clk  (clk),
    .data (snap_q),
    .sum  (tree_sum)
  );

  // Sum or mean; rounding add is one bit wider so it cannot wrap.
  always_comb begin
    rnd_c = {1'b0, tree_sum};
    res_c = tree_sum;
    if (MEAN != 0) begin
      if (ROUND != 0) rnd_c = {1'b0, tree_sum} + (OW+1)'(NS / 2);
      rnd_c = rnd_c >> N;
      res_c = (rnd_c > SAT) ? OW'(SAT) : OW'(rnd_c);
    end
  end

endmodule

// File: tb/tb_qnigma_sum_ctrl.sv
// Directed bench for qnigma_sum_ctrl: sum, truncating mean and rounding mean
// instances driven in lockstep from shared stimulus.

module tb_qnigma_sum_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 2;
  localparam int unsigned OW = W + N;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, out_ready;
  logic [W-1:0]  in_data;

  logic          in_ready_s, out_valid_s, busy_s;
  logic          in_ready_m, out_valid_m, busy_m;
  logic          in_ready_r, out_valid_r, busy_r;
  logic [OW-1:0] out_data_s, out_data_m, out_data_r;
  logic [N-1:0]  fill_s, fill_m, fill_r;

  always #5 clk = ~clk;

  qnigma_sum_ctrl #(.W(W), .N(N), .MEAN(0), .ROUND(0)) dut_sum (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_s), .out_data(out_data_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .busy(busy_s), .fill_cnt(fill_s));

  qnigma_sum_ctrl #(.W(W), .N(N), .MEAN(1), .ROUND(0)) dut_mean (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .out_data(out_data_m), .out_valid(out_valid_m),
    .out_ready(out_ready), .busy(busy_m), .fill_cnt(fill_m));

  qnigma_sum_ctrl #(.W(W), .N(N), .MEAN(1), .ROUND(1)) dut_rnd (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_r), .out_data(out_data_r), .out_valid(out_valid_r),
    .out_ready(out_ready), .busy(busy_r), .fill_cnt(fill_r));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] s [4];
    int         sum;
    int         mean;
    int         rnd;
    string      nm;
  } vec_t;

  vec_t vecs [7];

  // Waits for out_valid, dropping in_valid; lat counts edges after the last beat minus one.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid_s) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_frame(input vec_t v);
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v.s[i];
      #1;
      check({v.nm, "/fill"}, 64'(fill_s), 64'(i));
      check({v.nm, "/in_ready"}, 64'(in_ready_s), 64'd1);
    end
    wait_out(lat);
    check({v.nm, "/latency"}, 64'(lat), 64'd3);
    check({v.nm, "/sum"}, 64'(out_data_s), 64'(v.sum));
    check({v.nm, "/mean"}, 64'(out_data_m), 64'(v.mean));
    check({v.nm, "/round"}, 64'(out_data_r), 64'(v.rnd));
    check({v.nm, "/busy"}, 64'(busy_s), 64'd1);
    @(negedge clk);
    #1;
    check({v.nm, "/valid_one_cycle"}, 64'(out_valid_s), 64'd0);
  endtask

  // Streaming scoreboard state.
  int exp_q [$];
  int cyc = 0, last_v = -1, gaps_bad = 0, stalls = 0, got = 0, spurious = 0;

  task automatic stream_monitor();
    int e;
    if (out_valid_s) begin
      if (exp_q.size() == 0) begin
        spurious++;
      end else begin
        e = exp_q.pop_front();
        check("stream/sum", 64'(out_data_s), 64'(e));
        check("stream/mean", 64'(out_data_m), 64'(e >> 2));
        check("stream/round", 64'(out_data_r), 64'((((e + 2) >> 2) > 255) ? 255 : ((e + 2) >> 2)));
      end
      if (last_v >= 0 && (cyc - last_v) != 4) gaps_bad++;
      last_v = cyc;
      got++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, seen, acc, s;
    logic [7:0] bp [7];

    vecs[0] = '{'{8'd1,   8'd2,   8'd3,   8'd4},   10,   2,   3,   "inc"};
    vecs[1] = '{'{8'd255, 8'd255, 8'd255, 8'd254}, 1019, 254, 255, "near_max"};
    vecs[2] = '{'{8'd1,   8'd1,   8'd1,   8'd2},   5,    1,   1,   "quarter"};
    vecs[3] = '{'{8'd0,   8'd0,   8'd0,   8'd0},   0,    0,   0,   "zero"};
    vecs[4] = '{'{8'd255, 8'd255, 8'd255, 8'd255}, 1020, 255, 255, "max"};
    vecs[5] = '{'{8'd3,   8'd3,   8'd3,   8'd5},   14,   3,   4,   "half_up"};
    vecs[6] = '{'{8'd100, 8'd0,   8'd200, 8'd50},  350,  87,  88,  "mixed"};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset/in_ready", 64'(in_ready_s), 64'd1);
    check("reset/out_valid", 64'(out_valid_s), 64'd0);
    check("reset/busy", 64'(busy_s), 64'd0);
    check("reset/fill", 64'(fill_s), 64'd0);
    check("reset/mean_in_ready", 64'(in_ready_m), 64'd1);
    check("reset/round_busy", 64'(busy_r), 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) run_frame(vecs[v]);

    // Back-pressure: frame 2 stalls on its last sample until frame 1 is taken.
    bp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd20, 8'd30};
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = bp[i];
    end
    @(negedge clk);
    in_data = 8'd40;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("bp/in_ready_low", 64'(in_ready_s), 64'd0);
      check("bp/out_valid", 64'(out_valid_s), 64'd1);
      check("bp/hold_sum", 64'(out_data_s), 64'd10);
      check("bp/fill", 64'(fill_s), 64'd3);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp/in_ready_release", 64'(in_ready_s), 64'd1);
    check("bp/hold_round", 64'(out_data_r), 64'd3);
    wait_out(lat);
    check("bp/latency", 64'(lat), 64'd3);
    check("bp/sum2", 64'(out_data_s), 64'd100);
    check("bp/mean2", 64'(out_data_m), 64'd25);
    check("bp/round2", 64'(out_data_r), 64'd25);
    @(negedge clk);
    #1;
    check("bp/valid_drop", 64'(out_valid_s), 64'd0);
    check("bp/fill_after", 64'(fill_s), 64'd0);

    // Streaming: 64 back-to-back random frames.
    out_ready = 1'b1;
    for (int f = 0; f < 64; f++) begin
      acc = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        cyc++;
        stream_monitor();
        s = int'($urandom_range(0, 255));
        in_valid = 1'b1;
        in_data  = 8'(s);
        acc += s;
        if (i == 3) exp_q.push_back(acc);
        #1;
        if (!in_ready_s) stalls++;
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      stream_monitor();
    end
    check("stream/results", 64'(got), 64'd64);
    check("stream/stalls", 64'(stalls), 64'd0);
    check("stream/gap", 64'(gaps_bad), 64'd0);
    check("stream/spurious", 64'(spurious), 64'd0);
    check("stream/pending", 64'(exp_q.size()), 64'd0);

    // clr during SUM discards the frame.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd5;
    end
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("clr/busy", 64'(busy_s), 64'd0);
    check("clr/fill", 64'(fill_s), 64'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (out_valid_s) seen++;
    end
    check("clr/no_valid", 64'(seen), 64'd0);

    // clr together with a beat drops the sample.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd9;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    #1;
    check("clr_beat/fill", 64'(fill_s), 64'd0);
    run_frame('{'{8'd1, 8'd1, 8'd1, 8'd1}, 4, 1, 1, "after_clr"});

    // rst while holding a result.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd7;
    end
    wait_out(lat);
    check("rst/latency", 64'(lat), 64'd3);
    check("rst/held_sum", 64'(out_data_s), 64'd28);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst/out_valid", 64'(out_valid_s), 64'd0);
    check("rst/in_ready", 64'(in_ready_s), 64'd1);
    check("rst/busy", 64'(busy_s), 64'd0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
